// File: rtl/if_fetch_unit_if.sv
// ============================================================================
// Module      : if_fetch_unit_if
// Description : Instruction-memory fetch bus. The fetch unit drives request
//               and address; memory returns grant plus in-order responses.
//   req    master->slave  1   fetch request, held until granted
//   addr   master->slave  32  word-aligned fetch address
//   gnt    slave->master  1   request accepted this cycle (req & gnt)
//   rvalid slave->master  1   response valid, in request order
//   rdata  slave->master  32  response instruction word
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch stage. Issues in-order fetches on the imem
//               bus, buffers returned words with their pcs in a small queue
//               and presents the head to the IF/ID register. Stall holds the
//               head; flush redirects the pc and discards in-flight fetches.
// Ports       :
//   clk_i          in   clock, rising edge
//   rst_i          in   synchronous reset, active-high
//   stall_i        in   decode stalled, do not pop
//   flush_i        in   redirect to redirect_pc_i, drop fetch state
//   redirect_pc_i  in   restart address (bits [1:0] ignored)
//   imem           --   fetch bus, master side
//   instruction_o  out  head instruction, 0 when queue empty
//   pc_o           out  pc of head instruction, 0 when queue empty
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  wire              clk_i,
  input  wire              rst_i,
  input  wire              stall_i,
  input  wire              flush_i,
  input  wire [31:0]       redirect_pc_i,
  if_fetch_unit_if.master  imem,
  output logic [31:0]      instruction_o,
  output logic [31:0]      pc_o
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned SW = CW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q,  resp_pc_d;
  logic [CW-1:0] outst_q,    outst_d;
  logic [CW-1:0] discard_q,  discard_d;
  logic [CW-1:0] count_q,    count_d;
  logic [PW-1:0] head_q,     head_d;
  logic [PW-1:0] tail_q,     tail_d;
  logic [31:0]   q_pc_q    [QDEPTH];
  logic [31:0]   q_pc_d    [QDEPTH];
  logic [31:0]   q_instr_q [QDEPTH];
  logic [31:0]   q_instr_d [QDEPTH];

  logic [31:0]   redirect_aligned;
  logic [SW-1:0] credits_used;
  logic          req;
  logic          fire;
  logic          resp_ok;
  logic          drop;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign redirect_aligned = redirect_pc_i & 32'hFFFF_FFFC;

  // Outstanding requests plus buffered words may never exceed the queue
  // depth, so every response is guaranteed a free slot.
  assign credits_used = SW'(outst_q) + SW'(count_q);
  assign req          = ~rst_i & ~flush_i & (credits_used < SW'(QDEPTH));
  assign fire         = req & imem.gnt;

  // Guarded so a stray response can never wrap the counter.
  assign resp_ok = imem.rvalid & (outst_q != '0);
  assign drop    = resp_ok & (discard_q != '0);
  assign push    = resp_ok & ~drop;
  assign pop     = ~stall_i & ~flush_i & (count_q != '0);

  assign imem.req  = req;
  assign imem.addr = fetch_pc_q;

  assign instruction_o = (count_q != '0) ? q_instr_q[head_q] : 32'h0;
  assign pc_o          = (count_q != '0) ? q_pc_q[head_q]    : 32'h0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    q_pc_d     = q_pc_q;
    q_instr_d  = q_instr_q;

    if (resp_ok) outst_d = outst_d - CW'(1);
    if (fire)    outst_d = outst_d + CW'(1);

    if (flush_i) begin
      // No request fires in a flush cycle, so outst_d is exactly the
      // count of responses still to come; all of them are stale.
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      discard_d  = outst_d;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (drop) discard_d = discard_q - CW'(1);
      if (push) begin
        q_pc_d[tail_q]    = resp_pc_q;
        q_instr_d[tail_q] = imem.rdata;
        tail_d            = ptr_inc(tail_q);
        resp_pc_d         = resp_pc_q + 32'd4;
      end
      if (pop) head_d = ptr_inc(head_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Queue payload needs no reset: count_q gates everything read from it.
  always_ff @(posedge clk_i) begin
    q_pc_q    <= q_pc_d;
    q_instr_q <= q_instr_d;
  end

  a_rvalid_needs_outstanding : assert property (
    @(posedge clk_i) disable iff (rst_i) imem.rvalid |-> (outst_q != '0)
  );

endmodule

`default_nettype wire
